// File: rtl/ps2_scan_code_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the raw clock/data pair,
// deframes 11-bit frames and keeps a two-byte scan-code history.
module ps2_scan_code_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [15:0] key_press_o,
    output logic        byte_valid_o,
    output logic        parity_err_o,
    output logic        frame_err_o
);

    localparam int unsigned FcntW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FcntW-1:0] FcntLast = FcntW'(FILTER_LEN - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             filt_clk_q;
    logic [FcntW-1:0] filt_cnt_q;
    logic             strobe_q;
    state_e           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [ToW-1:0]   to_cnt_q;
    logic [15:0]      key_press_q;
    logic             byte_valid_q, parity_err_q, frame_err_q;

    // Two-flop synchronisers; both lines idle high so they reset to 1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Clock filter plus registered falling-edge strobe of the filtered clock.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (clk_s2_q != filt_clk_q) begin
                if (filt_cnt_q == FcntLast) begin
                    // FILTER_LEN-th differing sample: adopt the new level.
                    filt_clk_q <= clk_s2_q;
                    filt_cnt_q <= '0;
                    strobe_q   <= filt_clk_q;
                end else begin
                    filt_cnt_q <= filt_cnt_q + FcntW'(1);
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    // Frame deframer with timeout; outputs are registered pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            key_press_q  <= '0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (strobe_q) begin
                // A strobe always beats a coincident timeout.
                to_cnt_q <= '0;
                case (state_q)
                    StIdle: begin
                        if (!dat_s2_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= dat_s2_q;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        if (!dat_s2_q) begin
                            frame_err_q <= 1'b1;
                        end else if (^{shift_q, parity_q}) begin
                            key_press_q  <= {key_press_q[7:0], shift_q};
                            byte_valid_q <= 1'b1;
                        end else begin
                            parity_err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle) begin
                if (to_cnt_q == ToLast) begin
                    frame_err_q <= 1'b1;
                    state_q     <= StIdle;
                    to_cnt_q    <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + ToW'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign key_press_o  = key_press_q;
    assign byte_valid_o = byte_valid_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_code_receiver.sv
// Bench for the PS/2 receiver: directed frames, a frame-level model and a
// per-cycle compare against it, plus literal checks of key history.
module tb_ps2_scan_code_receiver;

    localparam int FL   = 8;
    localparam int TO   = 3000;
    localparam int HALF = 30;
    localparam int LAT  = FL + 3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_press;
    logic        byte_valid, parity_err, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run = 1'b0;

    // Model state: one pending frame outcome at a time.
    logic [15:0] exp_key = 16'h0000;
    int          ev_due = -1;
    int          ev_kind = 0;   // 0 accept, 1 parity error, 2 frame error
    logic [7:0]  ev_byte = 8'h00;
    int          rst_due = -1;
    int          bv_cnt = 0, pe_cnt = 0, fe_cnt = 0;

    ps2_scan_code_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .key_press_o (key_press),
        .byte_valid_o(byte_valid),
        .parity_err_o(parity_err),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (run) begin
            logic ebv, epe, efe;
            ebv = 1'b0;
            epe = 1'b0;
            efe = 1'b0;
            if (cyc == rst_due) begin
                exp_key = 16'h0000;
                ev_due  = -1;
            end
            if (cyc == ev_due) begin
                if (ev_kind == 0) begin
                    exp_key = {exp_key[7:0], ev_byte};
                    ebv = 1'b1;
                end else if (ev_kind == 1) begin
                    epe = 1'b1;
                end else begin
                    efe = 1'b1;
                end
                ev_due = -1;
            end
            check("key_press", key_press, exp_key);
            check("byte_valid", {15'd0, byte_valid}, {15'd0, ebv});
            check("parity_err", {15'd0, parity_err}, {15'd0, epe});
            check("frame_err", {15'd0, frame_err}, {15'd0, efe});
            bv_cnt += int'(byte_valid);
            pe_cnt += int'(parity_err);
            fe_cnt += int'(frame_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clock out n bits LSB first; optionally schedule the model outcome
    // 'extra' cycles beyond the strobe latency of the last falling edge.
    task automatic send_bits(input logic [10:0] b, input int n, input bit sched, input int extra);
        for (int i = 0; i < n; i++) begin
            ps2_data = b[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (sched && i == n - 1) ev_due = cyc + LAT + extra;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        ev_byte = data;
        if (!stop) ev_kind = 2;
        else if (^{data, par}) ev_kind = 0;
        else ev_kind = 1;
        send_bits({stop, par, data, 1'b0}, 11, 1'b1, 0);
        tick(HALF + 40);
    endtask

    initial begin
        tick(5);
        reset_i = 1'b0;
        run = 1'b1;
        tick(1000);
        check("reset_key", key_press, 16'h0000);
        check("reset_pulses", 16'(bv_cnt + pe_cnt + fe_cnt), 16'd0);

        send_frame(8'h16, 1'b0, 1'b1);
        check("first_16", key_press, 16'h0016);
        check("first_bv_count", 16'(bv_cnt), 16'd1);

        send_frame(8'hF0, 1'b1, 1'b1);
        check("break_F0", key_press, 16'h16F0);
        send_frame(8'h16, 1'b0, 1'b1);
        check("release_F016", key_press, 16'hF016);
        check("bv_count_3", 16'(bv_cnt), 16'd3);
        send_frame(8'h16, 1'b0, 1'b1);
        check("repeat_1616", key_press, 16'h1616);

        send_frame(8'h1C, 1'b1, 1'b1);
        check("parity_err_count", 16'(pe_cnt), 16'd1);
        check("parity_key_kept", key_press, 16'h1616);
        send_frame(8'h1E, 1'b1, 1'b0);
        check("stop_err_count", 16'(fe_cnt), 16'd1);
        check("stop_key_kept", key_press, 16'h1616);

        // Five bits then silence: timeout abandons the partial frame.
        ev_kind = 2;
        send_bits(11'b000_0001_1100, 5, 1'b1, TO);
        tick(TO + 100);
        check("timeout_count", 16'(fe_cnt), 16'd2);
        check("timeout_key_kept", key_press, 16'h1616);
        send_frame(8'h1E, 1'b1, 1'b1);
        check("after_timeout_low", {8'h00, key_press[7:0]}, 16'h001E);
        check("after_timeout_key", key_press, 16'h161E);

        // Sub-threshold clock glitch with data low must not start a frame.
        ps2_data = 1'b0;
        tick(2);
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(40);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("after_glitch", key_press, 16'h1E1C);

        // Reset after four data bits.
        send_bits(11'b000_0001_0110 << 0, 5, 1'b0, 0);
        tick(20);
        reset_i = 1'b1;
        rst_due = cyc + 1;
        tick(1);
        reset_i = 1'b0;
        check("reset_mid_frame", key_press, 16'h0000);
        tick(100);
        send_frame(8'h16, 1'b0, 1'b1);
        check("after_reset_16", key_press, 16'h0016);
        check("total_bv", 16'(bv_cnt), 16'd7);
        check("total_pe", 16'(pe_cnt), 16'd1);
        check("total_fe", 16'(fe_cnt), 16'd2);

        tick(10);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
